scope_capture_buffer: RTL and testbench
=======================================

// Module: scope_capture_buffer
// PURPOSE
//  Trigger-and-capture stage directly downstream of the ADC-to-display mapper.
//  Takes the clipped 9-bit signed display sample and its ceil/floor overflow flags.
//  Detects a level/slope trigger and captures one screen-width frame with pre-trigger history into on-chip RAM.
//  The display renderer reads the frame by logical column until it releases the buffer.
// PARAMETERS
//  DEPTH         640      samples per frame (screen columns); need not be a power of two
//  AW            10       address width, 2**AW >= DEPTH
//  PRE_TRIG      320      samples kept before the trigger sample; 1 <= PRE_TRIG <= DEPTH-2
//  AUTO_TIMEOUT  1048576  sample_valid count in ARMED before an auto-mode forced trigger
// PORTS
//  clk             in   1    system clock
//  rst             in   1    synchronous, active-high reset
//  sample_valid    in   1    display_sig/flags valid this cycle
//  display_sig     in   9    signed sample, range -201..+201
//  ceil_overflow   in   1    sample clipped high
//  floor_overflow  in   1    sample clipped low
//  trig_level      in   9    signed trigger threshold
//  trig_slope      in   1    0 = rising, 1 = falling
//  trig_mode       in   2    00 auto, 01 normal, 10 single, 11 treated as normal
//  frame_done      in   1    renderer finished reading the frame (pulse)
//  rearm           in   1    user re-arm (pulse)
//  rd_addr         in   AW   logical column, 0 = oldest sample
//  rd_data         out  11   {ceil, floor, sig[8:0]}, registered
//  frame_ready     out  1    complete frame held, safe to read
//  triggered       out  1    held frame came from a real trigger (0 = auto timeout)
//  busy            out  1    capture in progress (PRE/ARMED/POST)
// BEHAVIOUR
//  - Reset (any state, including mid-capture): state=IDLE, wr_ptr=0, counters=0.
//    Outputs rd_data=0, frame_ready=0, triggered=0, busy=0. RAM contents are not cleared.
//  - The RAM is written only when sample_valid=1 in PRE, ARMED or POST.
//    On each write, wr_ptr advances with wrap: DEPTH-1 -> 0.
//  - IDLE: the next cycle goes to PRE, unless trig_mode=single, in which case IDLE waits for rearm.
//  - PRE: count PRE_TRIG written samples, then go to ARMED. Crossings during PRE are ignored.
//  - ARMED: keep writing circularly.
//    The first valid sample in ARMED only loads prev; it cannot trigger.
//    Rising trigger: prev < trig_level && cur >= trig_level.
//    Falling trigger: prev > trig_level && cur <= trig_level. Comparisons are signed.
//    On trigger: trig_addr := physical address of the current sample, triggered := 1, go to POST.
//    Auto mode only: when the timeout counter reaches AUTO_TIMEOUT, the current sample becomes the trigger
//    with triggered := 0.
//    The timeout counter clears on entry to ARMED.
//  - POST: write DEPTH-PRE_TRIG-1 more samples, then go to HOLD.
//  - HOLD: frame_ready=1, no writes, busy=0.
//    In auto/normal mode, frame_done or rearm -> PRE.
//    In single mode, only rearm -> PRE; frame_done is ignored.
//    frame_done and rearm in the same cycle -> PRE.
//  - frame_ready and triggered drop on the cycle after HOLD is left. triggered otherwise holds its value.
//  - trig_mode, trig_level and trig_slope are sampled live. A change takes effect on the next evaluated sample.
//  - Readout:
//    start = trig_addr-PRE_TRIG, +DEPTH if negative.
//    phys = start+rd_addr, -DEPTH if >= DEPTH.
//    rd_data appears 1 cycle after rd_addr. rd_addr >= DEPTH returns 0.
//    Reads are legal in any state; data is coherent only while frame_ready=1.
//  - No arithmetic on the sample itself; the 11-bit word is stored verbatim.
// STRUCTURE
//  - scope_pkg holds:
//    capture state codes IDLE/PRE/ARMED/POST/HOLD;
//    TRIG_AUTO/NORMAL/SINGLE codes;
//    SIG_W=9 and WORD_W=11 (sig plus the two flags).
//  - Sub-module capture_ram: simple dual-port RAM, DEPTH x WORD_W, synchronous write and registered read.
//  - The FSM, pointers and address mapping live in this module.
// TESTING (DEPTH=640, PRE_TRIG=320, AUTO_TIMEOUT=1000)
//  1. rst high 3 cycles mid-POST -> frame_ready=0, busy=0, triggered=0, rd_data=0.
//     Normal mode then restarts in PRE.
//  2. Normal, rising, level 0: feed 400x(-50) then 400x(+50).
//     -> frame_ready after 319 post samples; rd_addr 319 -> -50, rd_addr 320 -> +50, triggered=1.
//  3. Same stimulus with falling slope -> no trigger, busy stays 1.
//     Then feed +50 -> -50 -> trigger, with rd_addr 320 = -50.
//  4. Auto, constant 0, level 100 -> frame_ready exactly 320+1000+319 valid samples after PRE entry.
//     triggered=0.
//  5. Single mode: after a frame, frame_done -> remains HOLD. A rearm pulse -> busy=1 next cycle.
//  6. Crossing placed inside PRE -> ignored. A ceil_overflow sample (+201) reads back as word {1,0,201}.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared types and constants for the scope trigger/capture stage.
package scope_pkg;

    // Sample and stored-word widths: 9-bit signed sample plus ceil/floor flags.
    localparam int SIG_W  = 9;
    localparam int WORD_W = 11;

    // Capture sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_HOLD  = 3'd4
    } capture_state_e;

    // Trigger mode codes; 2'b11 behaves like normal.
    localparam logic [1:0] TRIG_AUTO   = 2'b00;
    localparam logic [1:0] TRIG_NORMAL = 2'b01;
    localparam logic [1:0] TRIG_SINGLE = 2'b10;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port frame RAM: synchronous write, registered read.
// The read register is cleared by reset and by an out-of-range read;
// the storage array itself is never cleared.
module capture_ram
    import scope_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [WORD_W-1:0] wd,
    input  logic              re,
    input  logic [AW-1:0]     ra,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] mem [0:DEPTH-1];

    // Store the incoming word at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Registered read; returns zero when the read is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (re) begin
            q <= mem[ra];
        end else begin
            q <= '0;
        end
    end

endmodule

// File: rtl/scope_capture_buffer.sv
// Trigger-and-capture stage: records pre-trigger history circularly, detects
// a level/slope crossing (or auto timeout), fills the rest of the frame and
// holds it for the renderer, which reads by logical column.
// Handshake: sample_valid qualifies display_sig and the flags in the same
// cycle; there is no back-pressure, samples outside PRE/ARMED/POST are dropped.
module scope_capture_buffer
    import scope_pkg::*;
#(
    parameter int DEPTH        = 640,
    parameter int AW           = 10,
    parameter int PRE_TRIG     = 320,
    parameter int AUTO_TIMEOUT = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [SIG_W-1:0]  display_sig,
    input  logic              ceil_overflow,
    input  logic              floor_overflow,
    input  logic [SIG_W-1:0]  trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        trig_mode,
    input  logic              frame_done,
    input  logic              rearm,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              frame_ready,
    output logic              triggered,
    output logic              busy,
    output capture_state_e    cap_state
);

    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_TRIG - 2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(AUTO_TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   PRE_X     = (AW+1)'(PRE_TRIG);

    capture_state_e    state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     cnt;
    logic [TW-1:0]     tmo_cnt;
    logic              have_prev;
    logic [SIG_W-1:0]  prev_sig;
    logic [AW-1:0]     trig_addr;

    logic              writing;
    logic              mode_single;
    logic              crossing;
    logic              timeout_hit;
    logic [AW:0]       start_x;
    logic [AW:0]       sum_x;
    logic [AW:0]       phys_x;
    logic              rd_en;
    logic [AW-1:0]     rd_phys;

    assign cap_state   = state;
    assign mode_single = (trig_mode == TRIG_SINGLE);
    assign writing     = sample_valid &&
                         (state == ST_PRE || state == ST_ARMED || state == ST_POST);

    // Signed level/slope crossing against the previous sample, plus auto timeout.
    always_comb begin
        logic rise_hit;
        logic fall_hit;
        rise_hit    = ($signed(prev_sig) < $signed(trig_level)) &&
                      ($signed(display_sig) >= $signed(trig_level));
        fall_hit    = ($signed(prev_sig) > $signed(trig_level)) &&
                      ($signed(display_sig) <= $signed(trig_level));
        crossing    = have_prev && (trig_slope ? fall_hit : rise_hit);
        timeout_hit = (trig_mode == TRIG_AUTO) && (tmo_cnt == TMO_LAST);
    end

    // Logical column -> physical RAM address, oldest sample at column 0.
    always_comb begin
        if ({1'b0, trig_addr} >= PRE_X) begin
            start_x = {1'b0, trig_addr} - PRE_X;
        end else begin
            start_x = {1'b0, trig_addr} + DEPTH_X - PRE_X;
        end
        sum_x   = start_x + {1'b0, rd_addr};
        phys_x  = (sum_x >= DEPTH_X) ? (sum_x - DEPTH_X) : sum_x;
        rd_phys = phys_x[AW-1:0];
        rd_en   = ({1'b0, rd_addr} < DEPTH_X);
    end

    // Capture sequencer with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            cnt         <= '0;
            tmo_cnt     <= '0;
            have_prev   <= 1'b0;
            prev_sig    <= '0;
            trig_addr   <= '0;
            frame_ready <= 1'b0;
            triggered   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (writing) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!mode_single || rearm) begin
                        state <= ST_PRE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (sample_valid) begin
                        if (cnt == PRE_LAST) begin
                            state     <= ST_ARMED;
                            cnt       <= '0;
                            tmo_cnt   <= '0;
                            have_prev <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (sample_valid) begin
                        prev_sig  <= display_sig;
                        have_prev <= 1'b1;
                        tmo_cnt   <= tmo_cnt + 1'b1;
                        if (crossing || timeout_hit) begin
                            trig_addr <= wr_ptr;
                            triggered <= crossing;
                            state     <= ST_POST;
                            cnt       <= '0;
                        end
                    end
                end
                ST_POST: begin
                    if (sample_valid) begin
                        if (cnt == POST_LAST) begin
                            state       <= ST_HOLD;
                            frame_ready <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (rearm || (frame_done && !mode_single)) begin
                        state       <= ST_PRE;
                        cnt         <= '0;
                        frame_ready <= 1'b0;
                        triggered   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (writing),
        .wa  (wr_ptr),
        .wd  ({ceil_overflow, floor_overflow, display_sig}),
        .re  (rd_en),
        .ra  (rd_phys),
        .q   (rd_data)
    );

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Directed bench for scope_capture_buffer with small timeout for auto mode.
module tb_scope_capture_buffer;
    import scope_pkg::*;

    localparam int DEPTH = 640;
    localparam int AW    = 10;

    localparam logic [8:0]  S_NEG50  = 9'h1CE;
    localparam logic [8:0]  S_POS50  = 9'h032;
    localparam logic [8:0]  S_POS201 = 9'h0C9;
    localparam logic [8:0]  S_ZERO   = 9'h000;
    localparam logic [10:0] W_NEG50  = 11'h1CE;
    localparam logic [10:0] W_POS50  = 11'h032;
    localparam logic [10:0] W_CEIL   = 11'h4C9;
    localparam logic [10:0] W_ZERO   = 11'h000;

    logic           clk = 1'b0;
    logic           rst;
    logic           sample_valid;
    logic [8:0]     display_sig;
    logic           ceil_overflow;
    logic           floor_overflow;
    logic [8:0]     trig_level;
    logic           trig_slope;
    logic [1:0]     trig_mode;
    logic           frame_done;
    logic           rearm;
    logic [AW-1:0]  rd_addr;
    logic [10:0]    rd_data;
    logic           frame_ready;
    logic           triggered;
    logic           busy;
    capture_state_e cap_state;

    int n_cmp = 0;
    int n_err = 0;

    scope_capture_buffer #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .PRE_TRIG     (320),
        .AUTO_TIMEOUT (1000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .display_sig    (display_sig),
        .ceil_overflow  (ceil_overflow),
        .floor_overflow (floor_overflow),
        .trig_level     (trig_level),
        .trig_slope     (trig_slope),
        .trig_mode      (trig_mode),
        .frame_done     (frame_done),
        .rearm          (rearm),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .frame_ready    (frame_ready),
        .triggered      (triggered),
        .busy           (busy),
        .cap_state      (cap_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive n valid samples, then drop valid; returns at a negedge.
    task automatic feed(input logic [8:0] sig, input logic c, input logic f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid   = 1'b1;
            display_sig    = sig;
            ceil_overflow  = c;
            floor_overflow = f;
        end
        @(negedge clk);
        sample_valid   = 1'b0;
        ceil_overflow  = 1'b0;
        floor_overflow = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic pulse_rearm();
        @(negedge clk);
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
    endtask

    task automatic read_col(input int col, output logic [10:0] word);
        @(negedge clk);
        rd_addr = AW'(col);
        @(negedge clk);
        word = rd_data;
    endtask

    initial begin
        logic [10:0] w;
        rst = 1'b1; sample_valid = 1'b0; display_sig = '0;
        ceil_overflow = 1'b0; floor_overflow = 1'b0;
        trig_level = S_ZERO; trig_slope = 1'b0; trig_mode = TRIG_NORMAL;
        frame_done = 1'b0; rearm = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(frame_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(cap_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);
        check("idle_to_pre", 32'(cap_state), 32'(ST_PRE));

        // 1: reset in the middle of POST
        feed(S_NEG50, 0, 0, 321);
        feed(S_POS50, 0, 0, 101);
        check("t1_in_post", 32'(cap_state), 32'(ST_POST));
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_ready", 32'(frame_ready), 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_trig", 32'(triggered), 0);
        check("t1_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check("t1_restart_pre", 32'(cap_state), 32'(ST_PRE));
        check("t1_restart_busy", 32'(busy), 1);

        // 2: normal rising at 0
        feed(S_NEG50, 0, 0, 400);
        feed(S_POS50, 0, 0, 319);
        check("t2_not_yet", 32'(frame_ready), 0);
        feed(S_POS50, 0, 0, 1);
        check("t2_ready", 32'(frame_ready), 1);
        check("t2_trig", 32'(triggered), 1);
        check("t2_busy", 32'(busy), 0);
        read_col(319, w); check("t2_col319", 32'(w), 32'(W_NEG50));
        read_col(320, w); check("t2_col320", 32'(w), 32'(W_POS50));
        read_col(0, w);   check("t2_col0", 32'(w), 32'(W_NEG50));
        read_col(639, w); check("t2_col639", 32'(w), 32'(W_POS50));
        read_col(640, w); check("t2_col640_oob", 32'(w), 32'(W_ZERO));

        // 3: falling slope, rising data does not trigger
        trig_slope = 1'b1;
        pulse_done();
        check("t3_ready_drop", 32'(frame_ready), 0);
        check("t3_trig_drop", 32'(triggered), 0);
        feed(S_NEG50, 0, 0, 400);
        feed(S_POS50, 0, 0, 400);
        check("t3_no_trig_busy", 32'(busy), 1);
        check("t3_no_trig_state", 32'(cap_state), 32'(ST_ARMED));
        feed(S_NEG50, 0, 0, 319);
        check("t3_not_yet", 32'(frame_ready), 0);
        feed(S_NEG50, 0, 0, 1);
        check("t3_ready", 32'(frame_ready), 1);
        check("t3_trig", 32'(triggered), 1);
        read_col(320, w); check("t3_col320", 32'(w), 32'(W_NEG50));
        read_col(319, w); check("t3_col319", 32'(w), 32'(W_POS50));

        // 4: auto timeout with no crossing
        trig_mode = TRIG_AUTO; trig_slope = 1'b0; trig_level = 9'd100;
        pulse_done();
        feed(S_ZERO, 0, 0, 320 + 1000 + 319 - 1);
        check("t4_not_yet", 32'(frame_ready), 0);
        feed(S_ZERO, 0, 0, 1);
        check("t4_ready", 32'(frame_ready), 1);
        check("t4_trig_auto", 32'(triggered), 0);
        read_col(100, w); check("t4_col100", 32'(w), 32'(W_ZERO));

        // 5: single mode ignores frame_done
        trig_mode = TRIG_SINGLE; trig_level = S_ZERO;
        pulse_rearm();
        check("t5_rearm_busy", 32'(busy), 1);
        feed(S_NEG50, 0, 0, 321);
        feed(S_POS50, 0, 0, 320);
        check("t5_ready", 32'(frame_ready), 1);
        pulse_done();
        repeat (2) @(negedge clk);
        check("t5_hold_ready", 32'(frame_ready), 1);
        check("t5_hold_state", 32'(cap_state), 32'(ST_HOLD));
        check("t5_hold_busy", 32'(busy), 0);
        pulse_rearm();
        check("t5_busy_next", 32'(busy), 1);

        // 6: crossing during PRE ignored; ceil sample stored verbatim
        trig_mode = 2'b11;
        feed(S_NEG50, 0, 0, 100);
        feed(S_POS50, 0, 0, 100);
        feed(S_NEG50, 0, 0, 120);
        check("t6_armed", 32'(cap_state), 32'(ST_ARMED));
        check("t6_not_ready", 32'(frame_ready), 0);
        feed(S_NEG50, 0, 0, 1);
        feed(S_POS201, 1, 0, 1);
        feed(S_POS50, 0, 0, 319);
        check("t6_ready", 32'(frame_ready), 1);
        check("t6_trig", 32'(triggered), 1);
        read_col(320, w); check("t6_col320_ceil", 32'(w), 32'(W_CEIL));
        read_col(319, w); check("t6_col319", 32'(w), 32'(W_NEG50));
        read_col(99, w);  check("t6_col99_pre_cross", 32'(w), 32'(W_POS50));
        read_col(199, w); check("t6_col199", 32'(w), 32'(W_NEG50));
        read_col(0, w);   check("t6_col0", 32'(w), 32'(W_NEG50));
        read_col(321, w); check("t6_col321", 32'(w), 32'(W_POS50));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
